// File: rtl/cpen391_pio_pkg.sv
// Shared register map, edge-type encodings and edge-selection helper for the
// CPEN391 input PIO.
package cpen391_pio_pkg;

    localparam logic [1:0] ADDR_DATA = 2'd0;
    localparam logic [1:0] ADDR_MASK = 2'd1;
    localparam logic [1:0] ADDR_RSVD = 2'd2;
    localparam logic [1:0] ADDR_EDGE = 2'd3;

    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_ANY  = 2;

    // Picks which debounced transitions count as captured edges.
    function automatic logic [31:0] edge_select(input logic [31:0] rise,
                                                input logic [31:0] fall,
                                                input int          edge_type);
        case (edge_type)
            EDGE_RISE: return rise;
            EDGE_FALL: return fall;
            default:   return rise | fall;
        endcase
    endfunction

endpackage

// File: rtl/cpen391_pio_in_irq_if.sv
// Avalon-MM slave bus bundle for the input PIO (word addressed, read latency 1).
interface cpen391_pio_in_irq_if;

    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata
    );

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata
    );

endinterface

// File: rtl/cpen391_debounce.sv
// One input bit: 2-flop synchronizer followed by a stable-count debouncer.
// DEBOUNCE_CYCLES=0 turns the debouncer into a plain register after the synchronizer.
module cpen391_debounce #(
    parameter int   DEBOUNCE_CYCLES = 50000,
    parameter logic RESET_VALUE     = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic dout
);

    logic r_s1;
    logic r_s2;
    logic r_deb;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s1 <= RESET_VALUE;
            r_s2 <= RESET_VALUE;
        end else begin
            r_s1 <= din;
            r_s2 <= r_s1;
        end
    end

    generate
        if (DEBOUNCE_CYCLES == 0) begin : g_bypass
            always_ff @(posedge clk or posedge reset) begin
                if (reset) r_deb <= RESET_VALUE;
                else       r_deb <= r_s2;
            end
        end else begin : g_count
            localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
            localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

            logic [CNT_W-1:0] r_cnt;

            // Any return to the accepted level restarts the count, so glitches never leak.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_cnt <= '0;
                    r_deb <= RESET_VALUE;
                end else if (r_s2 == r_deb) begin
                    r_cnt <= '0;
                end else if (r_cnt == CNT_LAST) begin
                    r_deb <= r_s2;
                    r_cnt <= '0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end
    endgenerate

    assign dout = r_deb;

endmodule

// File: rtl/cpen391_pio_in_irq.sv
// Avalon-MM input PIO: debounced inputs, sticky edge capture (W1C), masked level IRQ.
// One instance per pushbutton/switch bank on the lightweight bridge.
module cpen391_pio_in_irq
    import cpen391_pio_pkg::*;
#(
    parameter int               WIDTH             = 10,
    parameter int               DEBOUNCE_CYCLES   = 50000,
    parameter int               EDGE_TYPE         = EDGE_ANY,
    parameter logic [WIDTH-1:0] INPUT_RESET_VALUE = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    cpen391_pio_in_irq_if.slave   bus,
    input  logic [WIDTH-1:0]      in_port,
    output logic                  irq
);

    logic [WIDTH-1:0] w_deb;
    logic [WIDTH-1:0] w_rise;
    logic [WIDTH-1:0] w_fall;
    logic [WIDTH-1:0] w_set;
    logic [WIDTH-1:0] w_clr;
    logic [WIDTH-1:0] w_edge_nxt;
    logic [31:0]      w_rdmux;
    logic             w_wr;

    logic [WIDTH-1:0] r_dprev;
    logic [WIDTH-1:0] r_mask;
    logic [WIDTH-1:0] r_edge;
    logic [31:0]      r_readdata;
    logic             r_irq;

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
            cpen391_debounce #(
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
                .RESET_VALUE     (INPUT_RESET_VALUE[gi])
            ) u_db (
                .clk   (clk),
                .reset (reset),
                .din   (in_port[gi]),
                .dout  (w_deb[gi])
            );
        end

        if (WIDTH < 32) begin : g_wdata_hi
            logic w_unused_wdata;
            assign w_unused_wdata = |bus.writedata[31:WIDTH];
        end
    endgenerate

    assign w_wr   = bus.chipselect && !bus.write_n;
    assign w_rise = w_deb & ~r_dprev;
    assign w_fall = ~w_deb & r_dprev;
    assign w_set  = WIDTH'(edge_select(32'(w_rise), 32'(w_fall), EDGE_TYPE));
    assign w_clr  = (w_wr && bus.address == ADDR_EDGE) ? bus.writedata[WIDTH-1:0] : '0;

    // Set is OR'd in after the clear so an edge arriving with a W1C is never lost.
    assign w_edge_nxt = (r_edge & ~w_clr) | w_set;

    always_comb begin
        w_rdmux = '0;
        case (bus.address)
            ADDR_DATA: w_rdmux = 32'(w_deb);
            ADDR_MASK: w_rdmux = 32'(r_mask);
            ADDR_EDGE: w_rdmux = 32'(r_edge);
            default:   w_rdmux = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_dprev    <= INPUT_RESET_VALUE;
            r_mask     <= '0;
            r_edge     <= '0;
            r_readdata <= '0;
            r_irq      <= 1'b0;
        end else begin
            r_dprev    <= w_deb;
            r_edge     <= w_edge_nxt;
            r_readdata <= w_rdmux;
            r_irq      <= |(r_edge & r_mask);
            if (w_wr && bus.address == ADDR_MASK)
                r_mask <= bus.writedata[WIDTH-1:0];
        end
    end

    assign bus.readdata = r_readdata;
    assign irq          = r_irq;

endmodule

// File: doc/cpen391_pio_in_irq.md
Name: cpen391_pio_in_irq

Overview:
- Avalon-MM slave input PIO for the CPEN391 Computer. It carries pushbutton and slide-switch levels from the board into the HPS/Nios address space, the opposite direction to the LED output PIO.
- Each input bit passes through a 2-flop synchronizer and a per-bit debouncer.
- Debounced edges are captured into a sticky edge register, and an IRQ line is driven from the edge register gated by a mask.
- The block sits on the lightweight bridge beside the other PIOs, one instance per input bank.

Parameters:
- WIDTH, 10: number of input bits (1..32).
- DEBOUNCE_CYCLES, 50000: consecutive stable cycles required to accept a new level; 0 bypasses the debouncer.
- EDGE_TYPE, 2: captured edge. 0 = rising, 1 = falling, 2 = any.
- INPUT_RESET_VALUE, 0: reset value of the synchronizer and debounced registers, per bit (WIDTH bits).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- address  in  2  Avalon word address.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe.
- writedata  in  32  write data.
- readdata  out  32  read data, registered.
- in_port  in  WIDTH  raw asynchronous board inputs.
- irq  out  1  level interrupt, active-high.

Behaviour:
- One clock; reset is asynchronous and active-high (clk, reset). All registers are cleared immediately on reset assertion, regardless of clk.
- Reset values:
  - sync stages = INPUT_RESET_VALUE; debounced = INPUT_RESET_VALUE.
  - debounce counters = 0; irq_mask = 0; edge_capture = 0.
  - readdata = 0; irq = 0.
- Synchronizer: in_port -> s1 -> s2, one flop each. s2 lags in_port by 2 cycles.
- Debouncer, per bit, with cnt sized $clog2(DEBOUNCE_CYCLES+1):
  - If s2 == debounced, then cnt <= 0.
  - Else if cnt == DEBOUNCE_CYCLES-1, then debounced <= s2 and cnt <= 0.
  - Else cnt <= cnt+1.
  - A glitch shorter than DEBOUNCE_CYCLES never changes debounced. The counter restarts whenever s2 returns to the debounced value.
  - Total latency from in_port to debounced is 2 + DEBOUNCE_CYCLES cycles. With DEBOUNCE_CYCLES=0, debounced <= s2 every cycle (latency 3).
- Edge detect: compare debounced with its previous value (d_prev, reset = INPUT_RESET_VALUE).
  - rise = debounced & ~d_prev; fall = ~debounced & d_prev.
  - The selected edge sets its edge_capture bit on the cycle after debounced changes.
- Register map (addresses are word addresses):
  - 0 DATA: read returns debounced, zero-extended. Writes are ignored.
  - 1 IRQ_MASK: read/write, bits [WIDTH-1:0]; upper bits read 0.
  - 2 reserved: reads 0, writes ignored.
  - 3 EDGE_CAPTURE: read returns edge_capture. Writing clears every bit where writedata is 1 (write-1-to-clear).
- Write happens when chipselect && !write_n. There is no wait-state; writes take effect at the next clk edge.
- Read: readdata <= mux(address) every cycle, giving read latency 1 (readLatency=1 in _hw.tcl). There is no chipselect gating on reads and no read side effects.
- Simultaneous set and clear of the same edge_capture bit: set wins, so the bit stays 1 and no edge is lost.
- irq = |(edge_capture & irq_mask), registered, so it asserts 1 cycle after the edge_capture bit sets.
  - Writing the mask to 0 deasserts irq 2 cycles after the write edge.
  - Clearing the last pending bit deasserts irq on the same schedule.
- Reset mid-debounce discards any in-progress count. Because debounced and d_prev reset equal, no edge is generated on reset release.
- Width rule: writedata bits [31:WIDTH] are ignored, and readdata bits [31:WIDTH] are always 0.

Decomposition:
- Package cpen391_pio_pkg holds:
  - ADDR_DATA=2'd0, ADDR_MASK=2'd1, ADDR_EDGE=2'd3;
  - EDGE_RISE=0, EDGE_FALL=1, EDGE_ANY=2.
- Sub-module cpen391_debounce: one bit wide, parameter DEBOUNCE_CYCLES, ports clk, reset, din, dout, plus reset-value parameter. It contains the synchronizer and the counter and is instantiated WIDTH times in a generate loop.
- The top level holds the edge detect, the registers and the Avalon mux.

Test Plan (WIDTH=4, DEBOUNCE_CYCLES=4, EDGE_TYPE=2, INPUT_RESET_VALUE=0 unless noted):
1. Reset while in_port=4'hF, then release. Required: readdata=0 and irq=0. DATA read reaches 0xF at cycle 2+4 after release, and the edge register reads 0xF.
2. in_port[0] pulses high for 3 cycles, then low. Required: DATA bit0 stays 0 and EDGE reads 0. A 6-cycle high pulse instead: DATA bit0=1, EDGE reads 0x1.
3. Write MASK=0x1 with edge bit0 pending. Required: irq=1 two cycles after the write. Then write EDGE=0x1: irq=0 two cycles later and EDGE reads 0.
4. Write EDGE=0x2 on the same cycle bit1 sets. Required: EDGE reads 0x2.
5. EDGE_TYPE=1, INPUT_RESET_VALUE=4'hF, in_port held 0xF then bit2 goes low. Required: no edges after reset; after bit2 goes low, EDGE=0x4, and the bit2 rising back leaves EDGE=0x4.
6. Assert reset mid-count (cnt=2), then release with the input still changed. Required: debounced holds its reset value until a full 4 stable cycles elapse after release.
